// File: rtl/bsg_clk_gen_tag_driver.sv
// Serial bsg_tag transmitter: sends start bit, node id, data/reset flag, length and
// payload LSB first, one bit per clk_i cycle, followed by gap_p idle zeros.
module bsg_clk_gen_tag_driver #(
  parameter int tag_els_p      = 1024,
  parameter int tag_lg_width_p = 4,
  parameter int gap_p          = 2,
  localparam int id_w          = (tag_els_p > 1) ? $clog2(tag_els_p) : 1,
  localparam int max_w         = (1 << tag_lg_width_p) - 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  output logic                      ready_and_o,
  input  logic [id_w-1:0]           node_id_i,
  input  logic                      data_not_reset_i,
  input  logic [tag_lg_width_p-1:0] len_i,
  input  logic [max_w-1:0]          payload_i,
  output logic                      tag_data_o,
  output logic                      busy_o
);

  localparam int cnt_max_a  = (id_w > tag_lg_width_p) ? id_w : tag_lg_width_p;
  localparam int cnt_max_b  = (max_w > gap_p) ? max_w : gap_p;
  localparam int cnt_max    = (cnt_max_a > cnt_max_b) ? cnt_max_a : cnt_max_b;
  localparam int cnt_w      = (cnt_max + 1 > 1) ? $clog2(cnt_max + 1) : 1;
  localparam int gap_last_i = (gap_p > 0) ? gap_p - 1 : 0;

  localparam logic [cnt_w-1:0] id_last_c  = cnt_w'(id_w - 1);
  localparam logic [cnt_w-1:0] len_last_c = cnt_w'(tag_lg_width_p - 1);
  localparam logic [cnt_w-1:0] gap_last_c = cnt_w'(gap_last_i);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    ID      = 3'd2,
    DNR     = 3'd3,
    LEN     = 3'd4,
    PAYLOAD = 3'd5,
    GAP     = 3'd6
  } state_e;

  // With no gap configured the frame ends straight back in IDLE
  localparam state_e tail_c = (gap_p > 0) ? GAP : IDLE;

  state_e                      state_r;
  logic [cnt_w-1:0]            cnt_r;
  logic [id_w-1:0]             id_r;
  logic                        dnr_r;
  logic [tag_lg_width_p-1:0]   len_r;
  logic [max_w-1:0]            payload_r;
  logic                        tag_r;

  logic [cnt_w-1:0]            cnt_nxt_s;
  logic                        id_bit_s;
  logic                        len_bit_s;
  logic                        pl_bit_s;
  logic                        pl_last_s;

  assign ready_and_o = (state_r == IDLE) & ~reset_i;
  assign busy_o      = (state_r != IDLE);
  assign tag_data_o  = tag_r;

  // Select the bit that follows the current one within each shadowed field
  always_comb begin
    cnt_nxt_s = cnt_r + cnt_w'(1'b1);
    id_bit_s  = 1'(id_r >> cnt_nxt_s);
    len_bit_s = 1'(len_r >> cnt_nxt_s);
    pl_bit_s  = 1'(payload_r >> cnt_nxt_s);
    pl_last_s = (cnt_r == (cnt_w'(len_r) - cnt_w'(1'b1)));
  end

  // Frame sequencer; tag_r is loaded with the bit belonging to the state being entered
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= IDLE;
      cnt_r     <= {cnt_w{1'b0}};
      id_r      <= {id_w{1'b0}};
      dnr_r     <= 1'b0;
      len_r     <= {tag_lg_width_p{1'b0}};
      payload_r <= {max_w{1'b0}};
      tag_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= {cnt_w{1'b0}};
          if (v_i) begin
            id_r      <= node_id_i;
            dnr_r     <= data_not_reset_i;
            len_r     <= len_i;
            payload_r <= payload_i;
            state_r   <= START;
            tag_r     <= 1'b1;
          end else begin
            state_r   <= IDLE;
            tag_r     <= 1'b0;
          end
        end
        START: begin
          state_r <= ID;
          cnt_r   <= {cnt_w{1'b0}};
          tag_r   <= id_r[0];
        end
        ID: begin
          if (cnt_r == id_last_c) begin
            state_r <= DNR;
            cnt_r   <= {cnt_w{1'b0}};
            tag_r   <= dnr_r;
          end else begin
            cnt_r   <= cnt_nxt_s;
            tag_r   <= id_bit_s;
          end
        end
        DNR: begin
          state_r <= LEN;
          cnt_r   <= {cnt_w{1'b0}};
          tag_r   <= len_r[0];
        end
        LEN: begin
          if (cnt_r == len_last_c) begin
            cnt_r <= {cnt_w{1'b0}};
            if (len_r != {tag_lg_width_p{1'b0}}) begin
              state_r <= PAYLOAD;
              tag_r   <= payload_r[0];
            end else begin
              state_r <= tail_c;
              tag_r   <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_nxt_s;
            tag_r <= len_bit_s;
          end
        end
        PAYLOAD: begin
          if (pl_last_s) begin
            state_r <= tail_c;
            cnt_r   <= {cnt_w{1'b0}};
            tag_r   <= 1'b0;
          end else begin
            cnt_r   <= cnt_nxt_s;
            tag_r   <= pl_bit_s;
          end
        end
        GAP: begin
          tag_r <= 1'b0;
          if (cnt_r == gap_last_c) begin
            state_r <= IDLE;
            cnt_r   <= {cnt_w{1'b0}};
          end else begin
            cnt_r   <= cnt_nxt_s;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {cnt_w{1'b0}};
          tag_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bsg_clk_gen_tag_driver.md
Name: bsg_clk_gen_tag_driver

Overview:
- Transmitter side of the bsg_tag serial interface feeding the clock generator block's tag master.
- Accepts one tag packet per valid/ready handshake: destination node id, data/reset flag, length and payload.
- Serializes each packet as one bit per clk_i cycle on tag_data_o, followed by an idle gap.
- Used on-chip by boot/config controllers, and in benches, to program oscillator, downsampler, select and monitor-reset clients without an off-chip tag driver.

Parameters:
- tag_els_p, 1024, number of tag clients addressed; node id width id_w = `BSG_SAFE_CLOG2(tag_els_p).
- tag_lg_width_p, 4, width of the length field; max payload bits max_w = (1<<tag_lg_width_p)-1.
- gap_p, 2, zero cycles forced after every frame before the next start bit; legal range 0..15.

Ports:
- clk_i, in, 1, transmit clock; also drives the tag master's tag_clk_i.
- reset_i, in, 1, synchronous active-high reset.
- v_i, in, 1, packet valid.
- ready_and_o, out, 1, driver can accept a packet this cycle.
- node_id_i, in, id_w, destination client id.
- data_not_reset_i, in, 1, 1 = data packet, 0 = client reset packet.
- len_i, in, tag_lg_width_p, number of payload bits to send.
- payload_i, in, max_w, payload; bit 0 is sent first.
- tag_data_o, out, 1, registered serial output.
- busy_o, out, 1, high from accept until the last gap cycle completes.

Behaviour:
- Frame format, every field LSB first, fixed:
  - start bit 1
  - node_id (id_w bits)
  - data_not_reset (1 bit)
  - len (tag_lg_width_p bits)
  - payload (len bits)
  - total 2 + id_w + tag_lg_width_p + len bits, then gap_p zeros.
- Reset: state=IDLE; tag_data_o=0; busy_o=0; ready_and_o=1 in the cycle after reset_i deasserts. Counters and shadow registers are cleared.
- Handshake:
  - ready_and_o = (state==IDLE) & ~reset_i.
  - Accept occurs when v_i & ready_and_o; all inputs are captured into shadow registers.
  - Inputs are don't-care after accept.
- Latency: start bit appears on tag_data_o in the cycle after accept; each following bit holds for exactly one cycle.
- States:
  - IDLE: tag_data_o=0. On accept -> START.
  - START: drive 1 -> ID.
  - ID: id_w cycles, bit cnt of node id -> DNR.
  - DNR: 1 cycle -> LEN.
  - LEN: tag_lg_width_p cycles -> PAYLOAD if len!=0, else GAP (or IDLE if gap_p==0).
  - PAYLOAD: len cycles -> GAP (or IDLE if gap_p==0).
  - GAP: gap_p cycles driving 0 -> IDLE.
- Counter: one bit counter, width `BSG_SAFE_CLOG2(max(id_w, tag_lg_width_p, max_w, gap_p)+1). Cleared on every state change; the field ends when cnt == field_len-1.
- busy_o = (state != IDLE).
- len_i == 0: no PAYLOAD state is entered; payload_i is ignored.
- Payload bits above len are never transmitted.
- Back-to-back packets: with v_i held high, the next accept occurs in the IDLE cycle. Minimum frame-to-frame spacing = gap_p + 1 zero cycles.
- reset_i mid-frame: next cycle is IDLE with tag_data_o=0 and the frame is truncated. The receiver recovers only through the system-level tag reset sequence, which is not this block's job.
- v_i while busy: ignored (ready_and_o=0). No packet is dropped silently, because the source must observe ready.

Test Plan:
- Basic frame (tag_els_p=16, tag_lg_width_p=4, gap_p=2): accept id=5, dnr=1, len=3, payload=3'b101 at cycle T. Required tag_data_o on cycles T+1..T+13 = 1, 1,0,1,0, 1, 1,1,0,0, 1,0,1. Then 0,0 on T+14..T+15, ready_and_o=1 at T+16, busy_o high T+1..T+15.
- Zero length: id=0, dnr=0, len=0 -> 10 bits 1,0,0,0,0,0,0,0,0,0, then gap. payload_i=all ones is never visible.
- Max length: len=15, payload=15'h5555 -> 25-bit frame, last 15 bits alternate 1,0,…,1. Total busy = 25+gap_p cycles.
- Back-to-back: v_i held high with two packets -> exactly gap_p+1 zero cycles between the last bit of frame 1 and the start bit of frame 2. ready_and_o is high only in the IDLE cycle.
- Reset mid-payload: assert reset_i during payload bit 2 -> next cycle tag_data_o=0, busy_o=0, ready_and_o=1 after deassert. A fresh packet then transmits correctly.
- Stall: v_i pulsed while busy -> no capture. Shadow node id is unchanged and the frame completes with the original contents.
